// File: rtl/sm_hex_display_scan.sv
// ---------------------------------------------------------------------------
// sm_hex_display_scan
//
// Time-multiplexed scanner for a multi-digit seven-segment display. Each digit
// owns one slot of SLOT_CYCLES clocks. The first BLANK_CYCLES clocks of every
// slot are dead time, so ghosting cannot occur between neighbouring digits.
// The display contents are snapshotted once per frame, at the start of digit
// 0's slot, so that a frame never mixes old and new data.
//
// Ports
//   clkIn       single clock
//   rst_n       asynchronous, active-low reset
//   enable      display on when 1 (the scan keeps running when 0)
//   lzSuppress  leading-zero blanking when 1
//   hexData     4*DIGITS bits, nibble i drives digit i (digit 0 = LSD)
//   dpIn        decimal point per digit
//   digitMask   a digit is shown only when its bit is 1
//   seg         {g,f,e,d,c,b,a}, pin polarity set by SEG_ACTIVE_LOW
//   dp          decimal point, pin polarity set by SEG_ACTIVE_LOW
//   digit       one-hot digit select, pin polarity set by DIG_ACTIVE_LOW
//   frameTick   one-cycle pulse on the cycle after each frame snapshot
// ---------------------------------------------------------------------------
module sm_hex_display_scan #(
  parameter int DIGITS         = 3,
  parameter int SLOT_CYCLES    = 50000,
  parameter int BLANK_CYCLES   = 1000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic                  clkIn,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  lzSuppress,
  input  logic [4*DIGITS-1:0]   hexData,
  input  logic [DIGITS-1:0]     dpIn,
  input  logic [DIGITS-1:0]     digitMask,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     digit,
  output logic                  frameTick
);

  localparam int CNT_W = $clog2(SLOT_CYCLES);
  // A single-digit display still needs a 1-bit index to keep widths legal.
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic             SEG_INV   = (SEG_ACTIVE_LOW != 0);
  localparam logic             DIG_INV   = (DIG_ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

  typedef enum logic {
    ST_BLANK,
    ST_SHOW
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [CNT_W-1:0]    slot_cnt;
  logic [CNT_W-1:0]    slot_cnt_next;
  logic [IDX_W-1:0]    idx;
  logic [IDX_W-1:0]    idx_next;
  logic                frame_start;

  logic [4*DIGITS-1:0] snap_hex;
  logic [DIGITS-1:0]   snap_dp;
  logic [DIGITS-1:0]   snap_mask;
  logic                snap_lz;

  logic [DIGITS-1:0]   upper_zero;
  logic                run_zero;
  logic [DIGITS-1:0]   sel_onehot;
  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                cur_mask;
  logic                cur_blank;

  logic [6:0]          seg_next;
  logic                dp_next;
  logic [DIGITS-1:0]   digit_next;

  // Seven-segment decode, logical active-high {g,f,e,d,c,b,a}.
  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] pattern;
    pattern = 7'h00;
    case (nib)
      4'h0: pattern = 7'h3F;
      4'h1: pattern = 7'h06;
      4'h2: pattern = 7'h5B;
      4'h3: pattern = 7'h4F;
      4'h4: pattern = 7'h66;
      4'h5: pattern = 7'h6D;
      4'h6: pattern = 7'h7D;
      4'h7: pattern = 7'h07;
      4'h8: pattern = 7'h7F;
      4'h9: pattern = 7'h6F;
      4'hA: pattern = 7'h77;
      4'hB: pattern = 7'h7C;
      4'hC: pattern = 7'h39;
      4'hD: pattern = 7'h5E;
      4'hE: pattern = 7'h79;
      4'hF: pattern = 7'h71;
      default: pattern = 7'h00;
    endcase
    return pattern;
  endfunction

  assign frame_start = (slot_cnt == '0) && (idx == '0);

  // upper_zero[i] is set when nibble i and every more significant nibble
  // are zero; it is walked from the top digit down.
  always_comb begin
    upper_zero = '0;
    run_zero   = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      run_zero      = run_zero & (snap_hex[4*i +: 4] == 4'd0);
      upper_zero[i] = run_zero;
    end
  end

  // Pick out the snapshot fields for the digit currently being scanned.
  // Digit 0 is never leading-zero blanked, so a value of 0 still shows "0".
  always_comb begin
    sel_onehot = '0;
    cur_nib    = 4'd0;
    cur_dp     = 1'b0;
    cur_mask   = 1'b0;
    cur_blank  = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        sel_onehot[i] = 1'b1;
        cur_nib       = snap_hex[4*i +: 4];
        cur_dp        = snap_dp[i];
        cur_mask      = snap_mask[i];
        cur_blank     = snap_lz && (i != 0) && upper_zero[i];
      end
    end
  end

  // Next-state logic: slot counter, digit index and BLANK/SHOW phase, plus
  // the logical output values for the current state.
  always_comb begin
    slot_cnt_next = slot_cnt + CNT_W'(1);
    idx_next      = idx;
    if (slot_cnt == CNT_LAST) begin
      slot_cnt_next = '0;
      idx_next      = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    end
    state_next = (slot_cnt_next < CNT_BLANK) ? ST_BLANK : ST_SHOW;

    seg_next   = 7'h00;
    dp_next    = 1'b0;
    digit_next = '0;
    if (enable && (state == ST_SHOW) && cur_mask) begin
      digit_next = sel_onehot;
      dp_next    = cur_dp;
      seg_next   = cur_blank ? 7'h00 : decode(cur_nib);
    end
  end

  // Scan counters run independently of enable so the scan phase never slips.
  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_BLANK;
      slot_cnt <= '0;
      idx      <= '0;
    end else begin
      state    <= state_next;
      slot_cnt <= slot_cnt_next;
      idx      <= idx_next;
    end
  end

  // Frame snapshot, taken only at the very start of digit 0's slot.
  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      snap_hex  <= '0;
      snap_dp   <= '0;
      snap_mask <= '0;
      snap_lz   <= 1'b0;
    end else if (frame_start) begin
      snap_hex  <= hexData;
      snap_dp   <= dpIn;
      snap_mask <= digitMask;
      snap_lz   <= lzSuppress;
    end
  end

  // Output registers. Reset drives the inactive pin levels directly so an
  // asynchronous reset can never pass through an active select.
  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      seg       <= {7{SEG_INV}};
      dp        <= SEG_INV;
      digit     <= {DIGITS{DIG_INV}};
      frameTick <= 1'b0;
    end else begin
      seg       <= seg_next ^ {7{SEG_INV}};
      dp        <= dp_next ^ SEG_INV;
      digit     <= digit_next ^ {DIGITS{DIG_INV}};
      frameTick <= frame_start;
    end
  end

endmodule

// File: tb/tb_sm_hex_display_scan.sv
// ---------------------------------------------------------------------------
// tb_sm_hex_display_scan
//
// Two scanners share every input: dut_a uses active-low pins, dut_b uses
// active-high pins. A reference model works from the elapsed cycle count since
// reset (slot position = t mod SLOT, digit = (t div SLOT) mod DIGITS) and
// queues the expected logical outputs; a monitor pops one entry per cycle and
// compares both DUTs after converting the expectation to each pin polarity.
// ---------------------------------------------------------------------------
module tb_sm_hex_display_scan;

  localparam int DIGITS = 3;
  localparam int SLOT   = 8;
  localparam int BLANK  = 2;
  localparam int FRAME  = DIGITS * SLOT;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [2:0] digit;
    logic       tick;
  } out_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        lz_suppress;
  logic [11:0] hex_data;
  logic [2:0]  dp_in;
  logic [2:0]  digit_mask;

  logic [6:0]  seg_a, seg_b;
  logic        dp_a, dp_b;
  logic [2:0]  digit_a, digit_b;
  logic        tick_a, tick_b;
  logic [11:0] pins_a, pins_b;

  int checks   = 0;
  int failures = 0;

  out_t        exp_q[$];
  int          model_t = 0;
  logic [3:0]  snap_nib [DIGITS];
  logic [2:0]  snap_dp   = '0;
  logic [2:0]  snap_mask = '0;
  logic        snap_lz   = 1'b0;
  int          m_pos, m_cur;
  logic        m_blank;
  out_t        m_exp;

  out_t        mon_exp;
  logic [2:0]  last_sel = '0;
  int          gap = 0;

  always #5 clk = ~clk;

  assign pins_a = {seg_a, dp_a, digit_a, tick_a};
  assign pins_b = {seg_b, dp_b, digit_b, tick_b};

  sm_hex_display_scan #(
    .DIGITS(DIGITS), .SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLANK),
    .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
  ) dut_a (
    .clkIn(clk), .rst_n(rst_n), .enable(enable), .lzSuppress(lz_suppress),
    .hexData(hex_data), .dpIn(dp_in), .digitMask(digit_mask),
    .seg(seg_a), .dp(dp_a), .digit(digit_a), .frameTick(tick_a)
  );

  sm_hex_display_scan #(
    .DIGITS(DIGITS), .SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLANK),
    .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)
  ) dut_b (
    .clkIn(clk), .rst_n(rst_n), .enable(enable), .lzSuppress(lz_suppress),
    .hexData(hex_data), .dpIn(dp_in), .digitMask(digit_mask),
    .seg(seg_b), .dp(dp_b), .digit(digit_b), .frameTick(tick_b)
  );

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic lz, input logic [11:0] hex,
                               input logic [2:0] dpv, input logic [2:0] mask);
    enable      = en;
    lz_suppress = lz;
    hex_data    = hex;
    dp_in       = dpv;
    digit_mask  = mask;
  endtask

  // Returns just after the negedge following a frame-start edge, i.e. while
  // the DUT presents slot position 0 of digit 0.
  task automatic wait_frame_start();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (((model_t % FRAME) != 1) && (n < 4 * FRAME));
    if ((model_t % FRAME) != 1) begin
      checks++;
      failures++;
      $display("[TB] FAIL frame_sync: no frame start within %0d cycles", 4 * FRAME);
    end
  endtask

  // Reference model: expected logical outputs produced by the edge at
  // elapsed cycle t after reset release.
  always @(posedge clk) begin
    m_exp = '0;
    if (!rst_n) begin
      model_t = 0;
    end else begin
      if ((model_t % FRAME) == 0) begin
        for (int j = 0; j < DIGITS; j++) snap_nib[j] = hex_data[4*j +: 4];
        snap_dp   = dp_in;
        snap_mask = digit_mask;
        snap_lz   = lz_suppress;
        m_exp.tick = 1'b1;
      end
      m_pos = model_t % SLOT;
      m_cur = (model_t / SLOT) % DIGITS;
      m_blank = 1'b0;
      if (snap_lz && (m_cur > 0)) begin
        m_blank = 1'b1;
        for (int j = m_cur; j < DIGITS; j++)
          if (snap_nib[j] != 4'd0) m_blank = 1'b0;
      end
      if (enable && (m_pos >= BLANK) && snap_mask[m_cur]) begin
        m_exp.digit[m_cur] = 1'b1;
        m_exp.dp           = snap_dp[m_cur];
        m_exp.seg          = m_blank ? 7'h00 : SEG_TABLE[snap_nib[m_cur]];
      end
      model_t++;
    end
    exp_q.push_back(m_exp);
  end

  // Monitor: one expectation per cycle, plus the one-hot and dead-time rules
  // observed directly on the active-high DUT.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
    end else begin
      mon_exp = '0;
      if (rst_n) checkOutput("queue_underflow", 16'd1, 16'd0);
    end
    if (!rst_n) mon_exp = '0;
    checkOutput("dut_a_pins", {4'b0, pins_a},
                {4'b0, mon_exp.seg ^ 7'h7F, ~mon_exp.dp, mon_exp.digit ^ 3'b111, mon_exp.tick});
    checkOutput("dut_b_pins", {4'b0, pins_b}, {4'b0, mon_exp});
    checkOutput("onehot", {15'b0, $countones(digit_b) <= 1}, 16'd1);
    if (digit_b != 3'b000) begin
      if ((last_sel != 3'b000) && (digit_b != last_sel))
        checkOutput("blank_gap", {15'b0, gap >= BLANK}, 16'd1);
      last_sel = digit_b;
      gap = 0;
    end else begin
      gap++;
    end
  end

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b1, 1'b0, 12'h3A7, 3'b000, 3'b111);
    repeat (3) @(negedge clk);
    checkOutput("reset_pins_a", {4'b0, pins_a}, {4'b0, 7'h7F, 1'b1, 3'b111, 1'b0});
    checkOutput("reset_pins_b", {4'b0, pins_b}, 16'h0000);

    // Scan order and mid-frame data change.
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("first_tick", {4'b0, pins_a}, {4'b0, 7'h7F, 1'b1, 3'b111, 1'b1});
    @(negedge clk);
    checkOutput("slot_blank", {4'b0, pins_a}, {4'b0, 7'h7F, 1'b1, 3'b111, 1'b0});
    @(negedge clk);
    checkOutput("digit0_7", {4'b0, pins_a}, {4'b0, 7'h78, 1'b1, 3'b110, 1'b0});
    hex_data = 12'h000;
    repeat (8) @(negedge clk);
    checkOutput("digit1_A", {4'b0, pins_a}, {4'b0, 7'h08, 1'b1, 3'b101, 1'b0});
    repeat (8) @(negedge clk);
    checkOutput("digit2_3", {4'b0, pins_a}, {4'b0, 7'h30, 1'b1, 3'b011, 1'b0});
    repeat (6) @(negedge clk);
    checkOutput("second_tick", {4'b0, pins_a}, {4'b0, 7'h7F, 1'b1, 3'b111, 1'b1});
    repeat (2) @(negedge clk);
    checkOutput("new_frame_0", {4'b0, pins_a}, {4'b0, 7'h40, 1'b1, 3'b110, 1'b0});

    // Leading-zero suppression.
    applyStimulus(1'b1, 1'b1, 12'h005, 3'b100, 3'b111);
    wait_frame_start();
    repeat (2) @(negedge clk);
    checkOutput("lz_digit0", {4'b0, pins_a}, {4'b0, 7'h12, 1'b1, 3'b110, 1'b0});
    repeat (8) @(negedge clk);
    checkOutput("lz_digit1", {4'b0, pins_a}, {4'b0, 7'h7F, 1'b1, 3'b101, 1'b0});
    repeat (8) @(negedge clk);
    checkOutput("lz_digit2", {4'b0, pins_a}, {4'b0, 7'h7F, 1'b0, 3'b011, 1'b0});

    // Active-high pins showing an '8'.
    applyStimulus(1'b1, 1'b0, 12'h888, 3'b000, 3'b111);
    wait_frame_start();
    repeat (2) @(negedge clk);
    checkOutput("high_pol_8", {4'b0, pins_b}, {4'b0, 7'h7F, 1'b0, 3'b001, 1'b0});

    // Mask: only digit 1 may be selected.
    applyStimulus(1'b1, 1'b0, 12'h123, 3'b000, 3'b010);
    wait_frame_start();
    repeat (2) @(negedge clk);
    checkOutput("mask_digit0", {4'b0, pins_b}, 16'h0000);
    repeat (8) @(negedge clk);
    checkOutput("mask_digit1", {4'b0, pins_b}, {4'b0, 7'h5B, 1'b0, 3'b010, 1'b0});

    // Enable off mid-frame; the model keeps its own phase.
    applyStimulus(1'b1, 1'b0, 12'h3A7, 3'b000, 3'b111);
    wait_frame_start();
    repeat (3) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    checkOutput("disabled", {4'b0, pins_a}, {4'b0, 7'h7F, 1'b1, 3'b111, 1'b0});
    repeat (30) @(negedge clk);
    enable = 1'b1;

    // Asynchronous reset in the middle of a SHOW interval.
    wait_frame_start();
    repeat (12) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 checkOutput("async_reset", {4'b0, pins_a}, {4'b0, 7'h7F, 1'b1, 3'b111, 1'b0});
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_tick", {4'b0, pins_a}, {4'b0, 7'h7F, 1'b1, 3'b111, 1'b1});
    repeat (2) @(negedge clk);
    checkOutput("post_reset_idx0", {4'b0, pins_a}, {4'b0, 7'h78, 1'b1, 3'b110, 1'b0});

    // Random run of 1000 frames.
    for (int c = 0; c < 1000 * FRAME; c++) begin
      @(negedge clk);
      if ($urandom_range(15) == 0)
        applyStimulus(enable, 1'($urandom_range(1)),
                      12'($urandom) >> (4 * $urandom_range(3)),
                      3'($urandom), 3'($urandom));
      if ($urandom_range(63) == 0) enable = ~enable;
    end

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
